// File: rtl/mul5_recon_pkg.sv
// rtl/mul5_recon_pkg.sv - shared constants and state encoding for the x = 5*q + r rebuilder
package mul5_recon_pkg;

  localparam int K         = 5;
  localparam int DIGIT     = 4;
  localparam int CW        = 3;
  localparam int WIDTH_DEF = 32;
  localparam int NSTEP     = WIDTH_DEF / DIGIT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul5_recon_serial_if.sv
// rtl/mul5_recon_serial_if.sv - operand/result handshake bundle for mul5_recon_serial
interface mul5_recon_serial_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_q;
  logic [2:0]       in_r;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+2:0] out_x;
  logic             out_err;

  modport master (
    output in_valid, in_q, in_r, out_ready,
    input  in_ready, out_valid, out_x, out_err
  );

  modport slave (
    input  in_valid, in_q, in_r, out_ready,
    output in_ready, out_valid, out_x, out_err
  );

endinterface

// File: rtl/mul5_digit_step.sv
// rtl/mul5_digit_step.sv - one digit of K*q: K*d + cin = s + (cout << DIGIT)
module mul5_digit_step #(
  parameter int DIGIT = 4,
  parameter int K     = 5
) (
  input  logic [DIGIT-1:0]                  d,
  input  logic [mul5_recon_pkg::CW-1:0]     cin,
  output logic [DIGIT-1:0]                  s,
  output logic [mul5_recon_pkg::CW-1:0]     cout
);

  import mul5_recon_pkg::*;

  localparam int PW = DIGIT + CW;

  logic [PW-1:0] p;

  // Every output bit depends only on DIGIT+CW inputs, so each maps to one wide LUT.
  assign p    = PW'(K) * PW'(d) + PW'(cin);
  assign s    = p[DIGIT-1:0];
  assign cout = p[PW-1:DIGIT];

endmodule

// File: rtl/mul5_recon_serial.sv
// rtl/mul5_recon_serial.sv - digit-serial rebuild of x = 5*q + r, LSB digit first
module mul5_recon_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4,
  parameter int K     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul5_recon_serial_if.slave   bus
);

  import mul5_recon_pkg::*;

  localparam int NSTEP_L = WIDTH / DIGIT;
  localparam int CNTW    = (NSTEP_L > 1) ? $clog2(NSTEP_L) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [CW-1:0]    carry_q, carry_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH+2:0] x_q, x_d;
  logic             out_err_q, out_err_d;

  logic [DIGIT-1:0] step_s;
  logic [CW-1:0]    step_cout;

  mul5_digit_step #(
    .DIGIT (DIGIT),
    .K     (K)
  ) u_step (
    .d    (q_sh_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (step_s),
    .cout (step_cout)
  );

  always_comb begin
    state_d   = state_q;
    q_sh_d    = q_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    x_d       = x_q;
    out_err_d = out_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // The remainder seeds the carry, so r is folded in by the first digit.
          state_d   = ST_RUN;
          q_sh_d    = bus.in_q;
          carry_d   = bus.in_r;
          cnt_d     = '0;
          err_d     = (bus.in_r >= 3'd5);
          x_d       = '0;
          out_err_d = 1'b0;
        end
      end
      ST_RUN: begin
        x_d[int'(cnt_q)*DIGIT +: DIGIT] = step_s;
        carry_d = step_cout;
        q_sh_d  = q_sh_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNTW'(NSTEP_L - 1)) begin
          x_d[WIDTH+2:WIDTH] = step_cout;
          out_err_d          = err_q;
          state_d            = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      q_sh_q    <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      x_q       <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_sh_q    <= q_sh_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      x_q       <= x_d;
      out_err_q <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_x     = x_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_mul5_recon_serial.sv
// tb/tb_mul5_recon_serial.sv - directed checks of mul5_recon_serial against hand-computed 5*q + r
module tb_mul5_recon_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul5_recon_serial_if #(.WIDTH(32)) bus ();

  mul5_recon_serial #(
    .WIDTH (32),
    .DIGIT (4),
    .K     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] q, input logic [2:0] r);
    @(negedge clk);
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_q     = q;
    bus.in_r     = r;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [31:0] q, input logic [2:0] r,
                        input logic [34:0] exp_x, input logic exp_err);
    start_op(q, r);
    check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    wait_result(tag, 8);
    check({tag, "_x"}, 64'(bus.out_x), 64'(exp_x));
    check({tag, "_err"}, 64'(bus.out_err), 64'(exp_err));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_q      = '0;
    bus.in_r      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_x", 64'(bus.out_x), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    rst_n = 1'b1;

    run_op("zero", 32'h0000_0000, 3'd0, 35'h0_0000_0000, 1'b0);
    run_op("ripple", 32'h3333_3333, 3'd1, 35'h1_0000_0000, 1'b0);
    run_op("max_legal", 32'hFFFF_FFFF, 3'd4, 35'h4_FFFF_FFFF, 1'b0);
    run_op("r5_err", 32'h0000_0001, 3'd5, 35'h0_0000_000A, 1'b1);
    run_op("r7_max", 32'hFFFF_FFFF, 3'd7, 35'h5_0000_0002, 1'b1);

    // Backpressure: result must hold, and a pending operand must wait for the handshake.
    start_op(32'h1234_5678, 3'd3);
    wait_result("hold", 8);
    bus.in_valid = 1'b1;
    bus.in_q     = 32'h0000_0007;
    bus.in_r     = 3'd0;
    for (int i = 0; i < 20; i++) begin
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_out_x", 64'(bus.out_x), 64'h0_5B05_B05B);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    check("hold_err", 64'(bus.out_err), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_drained", 64'(bus.out_valid), 64'd0);
    check("hold_pending_not_taken", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pending_accepted", 64'(bus.in_ready), 64'd0);
    wait_result("pending", 8);
    check("pending_x", 64'(bus.out_x), 64'd35);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of a run discards the partial result.
    start_op(32'hDEAD_BEEF, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_out_x", 64'(bus.out_x), 64'd0);
    check("abort_out_err", 64'(bus.out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(bus.out_valid), 64'd0);
    end
    run_op("after_abort", 32'h0000_0002, 3'd2, 35'h0_0000_000C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
